timer_counter: RTL and testbench

- Memory-mapped 32-bit down-counter peripheral; the device end of the CPU–timer bridge.
- Two instances sit behind the bridge: Timer0 at 0x0000_7F00–0x7F0B and Timer1 at 0x0000_7F10–0x7F1B.
- Takes word address, write enable and merged write data; returns a register read.
- Raises a maskable interrupt line that feeds a HWInt bit.

---
 rtl/timer_counter_pkg.sv | 30 +++
 rtl/timer_counter.sv | 102 ++++++++++
 tb/tb_timer_counter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - shared register map, CTRL fields, mode codes and FSM states for the timer
package timer_counter_pkg;

    // Word addresses within one timer window (byte address bits [3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Mode codes; every code other than MODE_AUTO behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    function automatic logic is_auto_reload(input logic [1:0] mode);
        return (mode == MODE_AUTO);
    endfunction

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped 32-bit down-counter with maskable level interrupt
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    state_t      state;

    logic        ctrl_wr;
    logic        run_en;

    // A CPU clear of Enable stops LOAD/CNT at the very edge that writes it,
    // so the count freezes at the value the CPU saw; IDLE waits on the
    // registered bit so a start costs one extra edge.
    assign ctrl_wr = WE && (Addr == ADDR_CTRL);
    assign run_en  = ctrl_wr ? Din[CTRL_ENABLE] : ctrl[CTRL_ENABLE];

    // Counter FSM plus register writes; writes come last so they win over FSM updates
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl[CTRL_ENABLE]) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!run_en) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= preset;
                        state <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (!run_en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // PRESET of 0 or 1 both land here straight after LOAD
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (is_auto_reload(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
                        irq_flag <= 1'b0;
                        state    <= ST_LOAD;
                    end else begin
                        ctrl[CTRL_ENABLE] <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (WE) begin
                case (Addr)
                    ADDR_CTRL: begin
                        ctrl     <= Din[3:0];
                        irq_flag <= 1'b0;
                    end
                    ADDR_PRESET: preset <= Din;
                    default: ;
                endcase
            end
        end
    end

    // Zero-latency read mux; reserved word reads as zero
    always_comb begin
        Dout = 32'd0;
        case (Addr)
            ADDR_CTRL:   Dout = {28'd0, ctrl};
            ADDR_PRESET: Dout = preset;
            ADDR_COUNT:  Dout = count;
            default:     Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed self-checking bench for timer_counter
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        checks++;
        assert (Dout === exp) else begin
            errors++;
            $error("FAIL %s: Dout=%h expected %h", tag, Dout, exp);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        checks++;
        assert (IRQ === exp) else begin
            errors++;
            $error("FAIL %s: IRQ=%b expected %b", tag, IRQ, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        Addr  = 2'd0;
        WE    = 1'b0;
        Din   = 32'd0;

        // Reset
        tick();
        tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) chk_reg("reset_dout", 2'(a), 32'd0);
        chk_irq("reset_irq", 1'b0);

        // One-shot, PRESET=5: IRQ 7 edges after the CTRL write
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick();
        chk_reg("os_load_count", 2'd2, 32'd0);
        for (int k = 5; k >= 1; k--) begin
            tick();
            chk_reg("os_count", 2'd2, 32'(k));
            chk_irq("os_irq_low", 1'b0);
        end
        tick();
        chk_reg("os_count_zero", 2'd2, 32'd0);
        chk_irq("os_irq_rise", 1'b1);
        tick();
        chk_reg("os_ctrl_cleared", 2'd0, 32'h8);
        chk_irq("os_irq_hold", 1'b1);
        tick();
        tick();
        chk_irq("os_irq_hold2", 1'b1);
        wr(2'd0, 32'h8);
        chk_irq("os_irq_clear", 1'b0);

        // Auto-reload, PRESET=3: one-cycle pulse every 5 cycles
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_irq("auto_irq_low", 1'b0);
            end
            tick();
            chk_irq("auto_irq_pulse", 1'b1);
            chk_reg("auto_enable_kept", 2'd0, 32'hB);
        end
        wr(2'd0, 32'h0);
        chk_irq("auto_stop_irq", 1'b0);
        tick();

        // Masked run: flag sets at edge 4 but IRQ stays low
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_irq("mask_irq_low", 1'b0);
        end
        chk_reg("mask_count_zero", 2'd2, 32'd0);
        tick();
        chk_reg("mask_oneshot_done", 2'd0, 32'h0);
        chk_irq("mask_irq_low2", 1'b0);

        // Abort while COUNT=1: count freezes
        wr(2'd0, 32'h1);
        tick();
        tick();
        chk_reg("abort_count2", 2'd2, 32'd2);
        tick();
        chk_reg("abort_count1", 2'd2, 32'd1);
        wr(2'd0, 32'h0);
        chk_reg("abort_frozen", 2'd2, 32'd1);
        tick();
        tick();
        tick();
        chk_reg("abort_frozen_later", 2'd2, 32'd1);
        chk_irq("abort_irq", 1'b0);

        // PRESET=0 and PRESET=1 both interrupt 3 edges after start
        for (int pv = 0; pv < 2; pv++) begin
            wr(2'd1, 32'(pv));
            wr(2'd0, 32'h9);
            tick();
            chk_irq("edge_irq_e1", 1'b0);
            tick();
            chk_reg("edge_loaded", 2'd2, 32'(pv));
            chk_irq("edge_irq_e2", 1'b0);
            tick();
            chk_irq("edge_irq_e3", 1'b1);
            chk_reg("edge_count_zero", 2'd2, 32'd0);
            wr(2'd0, 32'h8);
            chk_irq("edge_irq_clear", 1'b0);
            tick();
        end

        // Max PRESET, then writes to COUNT and reserved are ignored
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h1);
        tick();
        tick();
        chk_reg("max_loaded", 2'd2, 32'hFFFF_FFFF);
        tick();
        chk_reg("max_first_dec", 2'd2, 32'hFFFF_FFFE);
        wr(2'd2, 32'h0000_1234);
        chk_reg("count_wr_ignored", 2'd2, 32'hFFFF_FFFD);
        wr(2'd3, 32'h0000_0000);
        chk_reg("rsvd_wr_ignored", 2'd2, 32'hFFFF_FFFC);
        chk_reg("rsvd_reads_zero", 2'd3, 32'd0);
        chk_reg("preset_readback", 2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h0);
        chk_reg("max_abort_frozen", 2'd2, 32'hFFFF_FFFC);
        tick();

        // PRESET write in the LOAD cycle: old value loaded, new one on reload
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        tick();
        wr(2'd1, 32'd9);
        chk_reg("load_old_preset", 2'd2, 32'd2);
        chk_reg("preset_new", 2'd1, 32'd9);
        tick();
        chk_reg("load_dec", 2'd2, 32'd1);
        tick();
        chk_irq("load_irq", 1'b1);
        tick();
        chk_irq("load_irq_pulse_end", 1'b0);
        tick();
        chk_reg("reload_new_preset", 2'd2, 32'd9);
        wr(2'd0, 32'h0);
        chk_reg("reload_abort", 2'd2, 32'd9);
        tick();

        // CTRL write coincident with INT (one-shot): written value wins
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick();
        tick();
        tick();
        chk_irq("int_irq_set", 1'b1);
        wr(2'd0, 32'h9);
        chk_reg("int_ctrl_wins", 2'd0, 32'h9);
        chk_irq("int_flag_cleared", 1'b0);
        tick();
        tick();
        chk_reg("int_restart_load", 2'd2, 32'd1);
        tick();
        chk_irq("int_restart_irq", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
